// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage. Decodes the access size from the
// opcode, drives a single-outstanding data-memory request, stalls upstream
// until the memory acknowledges, then registers the instruction into MEM/WB
// with the lane-selected and extended load data.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses are trapped instead of issued. When it is undefined,
// misaligned addresses are force-aligned.
`timescale 1ns/1ps

module mem_access_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iPC,
    input  logic [31:0] iIR,
    input  logic [31:0] ialu_res,
    input  logic [31:0] iRS2,
    input  logic [4:0]  iwrite_addr,
    input  logic        imem_read,
    input  logic        imem_write,
    input  logic        imem_to_reg,
    input  logic        ipc_to_reg,
    input  logic        ireg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic [31:0] oPC,
    output logic [31:0] oIR,
    output logic [31:0] oalu_res,
    output logic [31:0] omem_data,
    output logic [4:0]  owrite_addr,
    output logic        oreg_write,
    output logic        omem_to_reg,
    output logic        opc_to_reg,
    output logic        omisalign
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  size;
    logic        load_signed;
    logic        mem_op;
    logic        is_load;
    logic        misalign;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic        pass;

    // When both read and write are set, the access is a store and the read is dropped.
    assign mem_op  = imem_read | imem_write;
    assign is_load = imem_read & ~imem_write;

    // Opcode decode: access width and signedness; unknown opcodes behave as word.
    always_comb begin
        size        = SZ_WORD;
        load_signed = 1'b0;
        case (iIR[31:26])
            6'h20: begin size = SZ_BYTE; load_signed = 1'b1; end
            6'h24: size = SZ_BYTE;
            6'h21: begin size = SZ_HALF; load_signed = 1'b1; end
            6'h25: size = SZ_HALF;
            6'h28: size = SZ_BYTE;
            6'h29: size = SZ_HALF;
            default: size = SZ_WORD;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op &
                      (((size == SZ_HALF) && ialu_res[0]) ||
                       ((size == SZ_WORD) && (ialu_res[1:0] != 2'b00)));
`else
    // Unused low address bits are simply ignored, so nothing is ever misaligned.
    assign misalign = 1'b0;
`endif

    // Store lane mask and data replication across the 32-bit bus.
    always_comb begin
        be_lane    = 4'b1111;
        wdata_lane = iRS2;
        case (size)
            SZ_BYTE: begin
                be_lane    = 4'b0001 << ialu_res[1:0];
                wdata_lane = {4{iRS2[7:0]}};
            end
            SZ_HALF: begin
                be_lane    = ialu_res[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{iRS2[15:0]}};
            end
            default: begin
                be_lane    = 4'b1111;
                wdata_lane = iRS2;
            end
        endcase
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (ialu_res[1:0])
            2'd0: byte_sel = dmem_rdata[7:0];
            2'd1: byte_sel = dmem_rdata[15:8];
            2'd2: byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = ialu_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size)
            SZ_BYTE: load_data = load_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            SZ_HALF: load_data = load_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            default: load_data = dmem_rdata;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, memory request and stall; pass selects full instruction vs bubble.
    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_be    = 4'b0000;
        dmem_wdata = 32'd0;
        pass       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_op && !misalign) begin
                    stall      = 1'b1;
                    state_next = ACCESS;
                end else begin
                    pass = 1'b1;
                end
            end
            ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = imem_write;
                dmem_addr  = {ialu_res[31:2], 2'b00};
                dmem_be    = be_lane;
                dmem_wdata = wdata_lane;
                if (dmem_ack) begin
                    pass       = 1'b1;
                    state_next = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Keep both handshake outputs quiet for the whole reset pulse.
        if (reset) begin
            stall    = 1'b0;
            dmem_req = 1'b0;
        end
    end

    // MEM/WB register: full instruction when pass, otherwise an all-zero bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oPC         <= 32'd0;
            oIR         <= 32'd0;
            oalu_res    <= 32'd0;
            omem_data   <= 32'd0;
            owrite_addr <= 5'd0;
            oreg_write  <= 1'b0;
            omem_to_reg <= 1'b0;
            opc_to_reg  <= 1'b0;
            omisalign   <= 1'b0;
        end else if (pass) begin
            oPC         <= iPC;
            oIR         <= iIR;
            oalu_res    <= ialu_res;
            omem_data   <= ((state_reg == ACCESS) && is_load) ? load_data : 32'd0;
            owrite_addr <= iwrite_addr;
            oreg_write  <= ireg_write & ~misalign;
            omem_to_reg <= imem_to_reg;
            opc_to_reg  <= ipc_to_reg;
            omisalign   <= misalign;
        end else begin
            oPC         <= 32'd0;
            oIR         <= 32'd0;
            oalu_res    <= 32'd0;
            omem_data   <= 32'd0;
            owrite_addr <= 5'd0;
            oreg_write  <= 1'b0;
            omem_to_reg <= 1'b0;
            opc_to_reg  <= 1'b0;
            omisalign   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: one task per scenario, inline checks,
// outputs sampled 1ns after the driving negedge or after the rising edge.
`timescale 1ns/1ps

module tb_mem_access_stage;

    logic        clock;
    logic        reset;
    logic [31:0] iPC, iIR, ialu_res, iRS2;
    logic [4:0]  iwrite_addr;
    logic        imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall;
    logic [31:0] oPC, oIR, oalu_res, omem_data;
    logic [4:0]  owrite_addr;
    logic        oreg_write, omem_to_reg, opc_to_reg, omisalign;

    int pass_cnt;
    int total_cnt;

    mem_access_stage dut (
        .clock(clock), .reset(reset),
        .iPC(iPC), .iIR(iIR), .ialu_res(ialu_res), .iRS2(iRS2),
        .iwrite_addr(iwrite_addr), .imem_read(imem_read), .imem_write(imem_write),
        .imem_to_reg(imem_to_reg), .ipc_to_reg(ipc_to_reg), .ireg_write(ireg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall),
        .oPC(oPC), .oIR(oIR), .oalu_res(oalu_res), .omem_data(omem_data),
        .owrite_addr(owrite_addr), .oreg_write(oreg_write), .omem_to_reg(omem_to_reg),
        .opc_to_reg(opc_to_reg), .omisalign(omisalign)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] wa, input logic rd,
                         input logic wr, input logic m2r, input logic rw);
        iIR         = {op, 26'h0001234};
        iPC         = pc;
        ialu_res    = alu;
        iRS2        = rs2;
        iwrite_addr = wa;
        imem_read   = rd;
        imem_write  = wr;
        imem_to_reg = m2r;
        ireg_write  = rw;
        ipc_to_reg  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive(6'h23, 32'h10, 32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) @(negedge clock);
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b expected 0", stall); else pass_cnt++;
        total_cnt++; if (dmem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", dmem_req); else pass_cnt++;
        total_cnt++; if ({oPC, oIR, oalu_res, omem_data} !== 128'd0) $display("FAIL rst_data: got %h expected 0", {oPC, oIR, oalu_res, omem_data}); else pass_cnt++;
        total_cnt++; if ({owrite_addr, oreg_write, omem_to_reg, opc_to_reg, omisalign} !== 9'd0) $display("FAIL rst_ctrl: got %h expected 0", {owrite_addr, oreg_write, omem_to_reg, opc_to_reg, omisalign}); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("reset: outputs cleared, stall=%b", stall);
    endtask

    task automatic test_alu();
        @(negedge clock);
        drive(6'h00, 32'h44, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        ipc_to_reg = 1'b1;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL alu_stall: got %b expected 0", stall); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (oalu_res !== 32'h1234) $display("FAIL alu_res: got %h expected 00001234", oalu_res); else pass_cnt++;
        total_cnt++; if ({oreg_write, opc_to_reg, owrite_addr} !== {1'b1, 1'b1, 5'd5}) $display("FAIL alu_ctrl: got %b expected 1100101", {oreg_write, opc_to_reg, owrite_addr}); else pass_cnt++;
        total_cnt++; if ({oPC, omem_data} !== {32'h44, 32'h0}) $display("FAIL alu_pc: got %h expected 0000004400000000", {oPC, omem_data}); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL alu_stall2: got %b expected 0", stall); else pass_cnt++;
        $display("alu: oalu_res=%h oreg_write=%b", oalu_res, oreg_write);
    endtask

    // lb at 0x103; ack withheld for three ACCESS cycles, giving four stalled cycles.
    task automatic test_load_byte();
        int stall_cycles;
        stall_cycles = 0;
        @(negedge clock);
        drive(6'h20, 32'h80, 32'h103, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_rdata = 32'h80FF_FF01;
        dmem_ack = 1'b0;
        #1;
        if (stall) stall_cycles++;
        total_cnt++; if (dmem_req !== 1'b0) $display("FAIL lb_idle_req: got %b expected 0", dmem_req); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (oreg_write !== 1'b0) $display("FAIL lb_bubble: got %b expected 0", oreg_write); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            if (stall) stall_cycles++;
            total_cnt++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h100}) $display("FAIL lb_wait_req: got %b/%b/%h expected 1/0/00000100", dmem_req, dmem_we, dmem_addr); else pass_cnt++;
        end
        @(negedge clock);
        dmem_ack = 1'b1;
        #1;
        if (stall) stall_cycles++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL lb_ack_stall: got %b expected 0", stall); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (omem_data !== 32'hFFFF_FF80) $display("FAIL lb_data: got %h expected ffffff80", omem_data); else pass_cnt++;
        total_cnt++; if ({oreg_write, omem_to_reg, owrite_addr, oPC} !== {1'b1, 1'b1, 5'd7, 32'h80}) $display("FAIL lb_ctrl: got %h expected %h", {oreg_write, omem_to_reg, owrite_addr, oPC}, {1'b1, 1'b1, 5'd7, 32'h80}); else pass_cnt++;
        total_cnt++; if (stall_cycles !== 4) $display("FAIL lb_stall_cycles: got %0d expected 4", stall_cycles); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        total_cnt++; if (dmem_req !== 1'b0) $display("FAIL lb_done_idle: got %b expected 0", dmem_req); else pass_cnt++;
        $display("lb @103: omem_data=%h stall_cycles=%0d", omem_data, stall_cycles);
    endtask

    task automatic test_store_half();
        @(negedge clock);
        drive(6'h29, 32'h90, 32'h22, 32'hAAAA_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL sh_stall: got %b expected 1", stall); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (oIR !== 32'h0) $display("FAIL sh_bubble: got %h expected 0", oIR); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b1;
        #1;
        total_cnt++; if ({dmem_req, dmem_we, dmem_be} !== {1'b1, 1'b1, 4'b1100}) $display("FAIL sh_req: got %b expected 111100", {dmem_req, dmem_we, dmem_be}); else pass_cnt++;
        total_cnt++; if ({dmem_addr, dmem_wdata} !== {32'h20, 32'hBEEF_BEEF}) $display("FAIL sh_bus: got %h expected 00000020beefbeef", {dmem_addr, dmem_wdata}); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL sh_ack_stall: got %b expected 0", stall); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if ({oIR, oalu_res, omem_data} !== {6'h29, 26'h0001234, 32'h22, 32'h0}) $display("FAIL sh_wb: got %h expected %h", {oIR, oalu_res, omem_data}, {6'h29, 26'h0001234, 32'h22, 32'h0}); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("sh @22: be=1100 wdata=beefbeef oIR=%h", oIR);
    endtask

    // lh then lbu, each acknowledged in its first ACCESS cycle.
    task automatic test_back_to_back();
        @(negedge clock);
        drive(6'h21, 32'hA0, 32'h2, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_rdata = 32'h8001_1234;
        @(negedge clock);
        dmem_ack = 1'b1;
        @(posedge clock); #1;
        total_cnt++; if (omem_data !== 32'hFFFF_8001) $display("FAIL lh_data: got %h expected ffff8001", omem_data); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(6'h24, 32'hA4, 32'h1, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_rdata = 32'h0000_F000;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL lbu_stall: got %b expected 1", stall); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b1;
        @(posedge clock); #1;
        total_cnt++; if ({omem_data, owrite_addr} !== {32'h0000_00F0, 5'd10}) $display("FAIL lbu_data: got %h expected %h", {omem_data, owrite_addr}, {32'h0000_00F0, 5'd10}); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("lh/lbu back to back: last omem_data=%h", omem_data);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clock);
        drive(6'h25, 32'hB0, 32'h4, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        #1;
        total_cnt++; if (dmem_req !== 1'b1) $display("FAIL rstm_req_before: got %b expected 1", dmem_req); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if ({dmem_req, stall} !== 2'b00) $display("FAIL rstm_async: got %b expected 00", {dmem_req, stall}); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if ({oPC, oIR, oalu_res, omem_data, owrite_addr, oreg_write, omem_to_reg, opc_to_reg, omisalign} !== 137'd0) $display("FAIL rstm_outs: got nonzero registered outputs"); else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        drive(6'h00, 32'hC0, 32'h55, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        dmem_ack = 1'b1;
        #1;
        total_cnt++; if ({dmem_req, stall} !== 2'b00) $display("FAIL rstm_idle: got %b expected 00", {dmem_req, stall}); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if ({oalu_res, omem_data} !== {32'h55, 32'h0}) $display("FAIL rstm_after: got %h expected 0000005500000000", {oalu_res, omem_data}); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("lhu @4 reset mid-access: dmem_req=%b", dmem_req);
    endtask

    task automatic test_misalign();
        @(negedge clock);
        drive(6'h23, 32'hD0, 32'h6, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        dmem_rdata = 32'h1234_5678;
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        total_cnt++; if ({dmem_req, stall} !== 2'b00) $display("FAIL mis_req: got %b expected 00", {dmem_req, stall}); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if ({omisalign, oreg_write, oalu_res} !== {1'b1, 1'b0, 32'h6}) $display("FAIL mis_trap: got %h expected %h", {omisalign, oreg_write, oalu_res}, {1'b1, 1'b0, 32'h6}); else pass_cnt++;
`else
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL mis_stall: got %b expected 1", stall); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b1;
        #1;
        total_cnt++; if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h4, 4'b1111}) $display("FAIL mis_align: got %h expected %h", {dmem_req, dmem_addr, dmem_be}, {1'b1, 32'h4, 4'b1111}); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if ({omem_data, omisalign, oreg_write} !== {32'h1234_5678, 1'b0, 1'b1}) $display("FAIL mis_wb: got %h expected %h", {omem_data, omisalign, oreg_write}, {32'h1234_5678, 1'b0, 1'b1}); else pass_cnt++;
`endif
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("lw @6: omisalign=%b omem_data=%h", omisalign, omem_data);
    endtask

    task automatic test_read_write();
        @(negedge clock);
        drive(6'h28, 32'hE0, 32'h1, 32'h5A, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        dmem_ack = 1'b1;
        #1;
        total_cnt++; if ({dmem_we, dmem_be, dmem_wdata} !== {1'b1, 4'b0010, 32'h5A5A_5A5A}) $display("FAIL rw_store: got %h expected %h", {dmem_we, dmem_be, dmem_wdata}, {1'b1, 4'b0010, 32'h5A5A_5A5A}); else pass_cnt++;
        @(posedge clock); #1;
        total_cnt++; if (omem_data !== 32'h0) $display("FAIL rw_memdata: got %h expected 0", omem_data); else pass_cnt++;
        @(negedge clock);
        dmem_ack = 1'b0;
        drive(6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("sb rd+wr @1: be=0010 omem_data=%h", omem_data);
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_alu();
        test_load_byte();
        test_store_half();
        test_back_to_back();
        test_reset_mid_access();
        test_misalign();
        test_read_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
